// File: rtl/data_mem_ws.sv
// Data memory with configurable wait states, RV32 sub-word loads/stores and error detection.
// Latency: response LATENCY+1 cycles after acceptance; busy (req_ready low) until the response cycle ends.
module data_mem_ws #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [DEPTH-1:0][31:0] init_mem();
        for (int i = 0; i < DEPTH; i++) begin
            init_mem[i] = 32'(i);
        end
    endfunction

    logic [DEPTH-1:0][31:0] mem = init_mem();

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_unsigned;

    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [1:0]  acc_size;
    logic        acc_unsigned;
    logic        acc_err;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word, wr_word, load_val;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // With LATENCY = 0 the access happens on the acceptance edge, before capture, so use live inputs in IDLE.
    always_comb begin
        acc_write    = cap_write;
        acc_addr     = cap_addr;
        acc_wdata    = cap_wdata;
        acc_size     = cap_size;
        acc_unsigned = cap_unsigned;
        if (state == IDLE) begin
            acc_write    = req_write;
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
        end
    end

    always_comb begin
        acc_err = (acc_size == 2'b11)
                | ((acc_size == 2'b01) && acc_addr[0])
                | ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
                | ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    end

    assign word_idx = acc_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign byte_v   = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign half_v   = rd_word[{acc_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        wr_word  = rd_word;
        case (acc_size)
            2'b00: begin
                load_val = acc_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
                wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
            end
            2'b01: begin
                load_val = acc_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
                wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
            end
            default: begin
                load_val = rd_word;
                wr_word  = acc_wdata;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt   = 4'(LATENCY);
                    state_nxt = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The array sits outside the reset branch: reset never clears it, and a held reset blocks any commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_write    <= 1'b0;
            cap_addr     <= 32'd0;
            cap_wdata    <= 32'd0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                cap_write    <= req_write;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
            end
            if (state_nxt == RESP) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_write) ? 32'd0 : load_val;
                if (acc_write && !acc_err) begin
                    mem[word_idx] <= wr_word;
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_ws.sv
// Directed bench for data_mem_ws: LATENCY=2 instance for functional cases, LATENCY=0 instance for back-to-back timing.
module tb_data_mem_ws;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_valid, z_write, z_unsigned;
    logic [31:0] z_addr, z_wdata;
    logic [1:0]  z_size;
    logic        z_ready, z_resp_valid, z_err;
    logic [31:0] z_rdata;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ws #(.DEPTH(128), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_ws #(.DEPTH(128), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_size(z_size),
        .req_unsigned(z_unsigned), .resp_valid(z_resp_valid),
        .resp_rdata(z_rdata), .resp_err(z_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request starting just after a rising edge; garbles inputs after acceptance.
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rd, input logic exp_err);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(negedge clk);
        chk({tag, ".rdy_c0"}, 32'(req_ready), 32'd1);
        chk({tag, ".vld_c0"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_write    = 1'b1;
        req_addr     = 32'h0;
        req_wdata    = 32'hFFFF_FFFF;
        req_size     = 2'b10;
        req_unsigned = ~uns;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            chk($sformatf("%s.rdy_c%0d", tag, c), 32'(req_ready), 32'd0);
            chk($sformatf("%s.vld_c%0d", tag, c), 32'(resp_valid), 32'(c == LAT + 1));
            if (c == LAT + 1) begin
                chk({tag, ".rdata"}, resp_rdata, exp_rd);
                chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, ".vld_after"}, 32'(resp_valid), 32'd0);
        chk({tag, ".rdy_after"}, 32'(req_ready), 32'd1);
        chk({tag, ".rdata_hold"}, resp_rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'b10; req_unsigned = 1'b0;
        z_valid = 1'b0; z_write = 1'b0; z_addr = 32'h0; z_wdata = 32'h0;
        z_size = 2'b10; z_unsigned = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;

        access("t1_ld8",  1'b0, 32'h08, 32'h0, 2'b10, 1'b0, 32'h0000_0002, 1'b0);

        access("t2_sb",   1'b1, 32'h11, 32'h0000_0080, 2'b00, 1'b0, 32'h0, 1'b0);
        access("t2_lb",   1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
        access("t2_lbu",  1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0);
        access("t2_lw",   1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0000_8004, 1'b0);

        access("t3_sh",   1'b1, 32'h22, 32'h1234_BEEF, 2'b01, 1'b0, 32'h0, 1'b0);
        access("t3_lh",   1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0);
        access("t3_lhu",  1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 32'h0000_BEEF, 1'b0);
        access("t3_lw",   1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hBEEF_0008, 1'b0);

        access("t4_sh_mis", 1'b1, 32'h03, 32'h0000_5555, 2'b01, 1'b0, 32'h0, 1'b1);
        access("t4_lw0",    1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
        access("t4_oor",    1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        access("t4_size3",  1'b0, 32'h04, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        access("t4_lb_ok",  1'b0, 32'h1FF, 32'h0, 2'b00, 1'b1, 32'h0000_0000, 1'b0);

        // Reset while the store is waiting: it must never commit nor respond
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h04;
        req_wdata = 32'hDEAD_BEEF; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5.vld_rst", 32'(resp_valid), 32'd0);
        chk("t5.rdy_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("t5.vld_c%0d", c), 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        access("t5_lw4", 1'b0, 32'h04, 32'h0, 2'b10, 1'b0, 32'h0000_0001, 1'b0);

        // Zero-latency instance: single load, then continuous valid
        z_valid = 1'b1; z_write = 1'b0; z_addr = 32'h0C; z_size = 2'b10;
        @(negedge clk);
        chk("t6.rdy_c0", 32'(z_ready), 32'd1);
        chk("t6.vld_c0", 32'(z_resp_valid), 32'd0);
        @(posedge clk); #1;
        z_addr = 32'h14;
        @(negedge clk);
        chk("t6.vld_c1", 32'(z_resp_valid), 32'd1);
        chk("t6.rdata_c1", z_rdata, 32'h0000_0003);
        chk("t6.rdy_c1", 32'(z_ready), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("t6.rdy_c%0d", k), 32'(z_ready), 32'((k % 2) == 0));
            chk($sformatf("t6.vld_c%0d", k), 32'(z_resp_valid), 32'((k % 2) == 1));
            if ((k % 2) == 1) begin
                chk($sformatf("t6.rdata_c%0d", k), z_rdata, 32'h0000_0005);
            end
        end
        z_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
